operand_mux_pipe: RTL and testbench

Parametrised N-to-1 operand selector with a configurable registered pipeline, used to feed ALU source operands (register, U-type immediate, PC, forwarded result) into the execute stage of the pipelined MCU. It replaces the fixed two-input combinational ALU source select. It adds:
- a registered, stall- and flush-aware output;
- a valid bit that travels with the data;
- a sticky flag for out-of-range selects.

---
 rtl/operand_mux_pkg.sv | 22 ++
 rtl/operand_pipe_reg.sv | 43 ++++
 rtl/operand_mux_pipe.sv | 70 +++++++
 tb/tb_operand_mux_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/operand_mux_pkg.sv
// Shared types and constants for the ALU source-operand selector.
package operand_mux_pkg;

  localparam int unsigned OPERAND_W = 32;

  typedef enum logic [1:0] {
    SEL_RS1   = 2'd0,
    SEL_UTYPE = 2'd1,
    SEL_PC    = 2'd2,
    SEL_FWD   = 2'd3
  } operand_sel_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] data;
    logic                 valid;
  } operand_stage_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_src);
    return sel < num_src;
  endfunction

endpackage

// File: rtl/operand_pipe_reg.sv
// One operand pipeline stage: flush clears, stall holds, otherwise load.
module operand_pipe_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             STALL,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] d_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (FLUSH) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!STALL) begin
      data_d  = d_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign d_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/operand_mux_pipe.sv
// N-to-1 ALU operand selector feeding a stall/flush-aware register pipeline,
// with a sticky flag for out-of-range selects.
module operand_mux_pipe
  import operand_mux_pkg::*;
#(
  parameter  int unsigned WIDTH      = OPERAND_W,
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned PIPE_DEPTH = 1,
  localparam int unsigned SEL_W      = $clog2(NUM_SRC)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC*WIDTH-1:0] SRC_IN,
  input  logic [SEL_W-1:0]         SEL,
  input  logic                     IN_VALID,
  input  logic                     STALL,
  input  logic                     FLUSH,
  input  logic                     CLR_ERR,
  output logic [WIDTH-1:0]         OUT,
  output logic                     OUT_VALID,
  output logic                     SEL_ERR
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_ok;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] stage_data  [PIPE_DEPTH+1];
  logic             stage_valid [PIPE_DEPTH+1];

  // Unmatched (out-of-range) selects fall through to zero.
  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (SEL == SEL_W'(k)) mux_data = SRC_IN[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok         = sel_in_range(32'(SEL), NUM_SRC);
  assign stage_data[0]  = mux_data;
  assign stage_valid[0] = IN_VALID;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    operand_pipe_reg #(.WIDTH(WIDTH)) u_reg (
      .CLK     (CLK),
      .RST     (RST),
      .FLUSH   (FLUSH),
      .STALL   (STALL),
      .d_i     (stage_data[i]),
      .valid_i (stage_valid[i]),
      .d_o     (stage_data[i+1]),
      .valid_o (stage_valid[i+1])
    );
  end

  // Only an accepted, valid bad select sets the flag; set beats clear.
  always_comb begin
    sel_err_d = sel_err_q & ~CLR_ERR;
    if (IN_VALID && !STALL && !FLUSH && !sel_ok) sel_err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign OUT       = stage_data[PIPE_DEPTH];
  assign OUT_VALID = stage_valid[PIPE_DEPTH];
  assign SEL_ERR   = sel_err_q;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe at pipe depths 1..3 plus a 5-source variant.
module tb_operand_mux_pipe;
  import operand_mux_pkg::*;

  logic         CLK, RST;
  logic [159:0] src;
  logic [2:0]   sel;
  logic         in_valid, stall, flush, clr_err;

  logic [31:0] out1, out2, out3, oute;
  logic        ov1, ov2, ov3, ove;
  logic        err1, err2, err3, erre;

  int n_vec = 0;
  int n_err = 0;

  // Stall phase tables (PIPE_DEPTH = 2)
  int c_in    [10] = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h14, 32'h14, 32'h14, 32'h15, 0, 0};
  int c_inv   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int c_stall [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int c_out   [10] = '{0, 32'h11, 32'h12, 32'h12, 32'h12, 32'h12, 32'h13, 32'h14, 32'h15, 0};
  int c_ov    [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  operand_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .PIPE_DEPTH(1)) u_d1 (
    .CLK(CLK), .RST(RST), .SRC_IN(src[127:0]), .SEL(sel[1:0]), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CLR_ERR(clr_err), .OUT(out1), .OUT_VALID(ov1), .SEL_ERR(err1));
  operand_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .PIPE_DEPTH(2)) u_d2 (
    .CLK(CLK), .RST(RST), .SRC_IN(src[127:0]), .SEL(sel[1:0]), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CLR_ERR(clr_err), .OUT(out2), .OUT_VALID(ov2), .SEL_ERR(err2));
  operand_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .PIPE_DEPTH(3)) u_d3 (
    .CLK(CLK), .RST(RST), .SRC_IN(src[127:0]), .SEL(sel[1:0]), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CLR_ERR(clr_err), .OUT(out3), .OUT_VALID(ov3), .SEL_ERR(err3));
  // Five sources give a 3-bit select, so indices 5..7 are genuinely out of range.
  operand_mux_pipe #(.WIDTH(32), .NUM_SRC(5), .PIPE_DEPTH(1)) u_e (
    .CLK(CLK), .RST(RST), .SRC_IN(src), .SEL(sel), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CLR_ERR(clr_err), .OUT(oute), .OUT_VALID(ove), .SEL_ERR(erre));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] s, input logic [31:0] val);
    in_valid = v;
    sel      = s;
    if (s < 3'd5) src[32'(s)*32 +: 32] = val;
  endtask

  initial begin
    RST = 1'b1; src = '0; sel = '0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; clr_err = 1'b0;

    // Reset holds outputs at zero even with a valid item presented
    set_in(1'b1, 3'(SEL_UTYPE), 32'hDEADBEEF);
    step(); step();
    chk("rst_out", out1, 32'h0);
    chk("rst_valid", 32'(ov1), 32'h0);
    chk("rst_err", 32'(erre), 32'h0);
    RST = 1'b0;
    step();
    chk("basic_out", out1, 32'hDEADBEEF);
    chk("basic_valid", 32'(ov1), 32'h1);
    chk("basic_d3_not_yet", 32'(ov3), 32'h0);

    // Empty all pipes
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_d3_valid", 32'(ov3), 32'h0);
    chk("flush_d1_out", out1, 32'h0);

    // Throughput and latency at depth 3: 1,2,3,4 back to back
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) set_in(1'b1, 3'(SEL_RS1), 32'(k));
      else        set_in(1'b0, 3'(SEL_RS1), 32'h0);
      step();
      chk($sformatf("tput_d3_v%0d", k), 32'(ov3), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("tput_d3_d%0d", k), out3, (k >= 3 && k <= 6) ? 32'(k - 2) : 32'h0);
      chk($sformatf("tput_d1_d%0d", k), out1, (k <= 4) ? 32'(k) : 32'h0);
    end

    // Three-cycle stall mid-stream at depth 2
    for (int j = 0; j < 10; j++) begin
      set_in(c_inv[j] != 0, 3'(SEL_RS1), 32'(c_in[j]));
      stall = (c_stall[j] != 0);
      step();
      chk($sformatf("stall_d2_d%0d", j), out2, 32'(c_out[j]));
      chk($sformatf("stall_d2_v%0d", j), 32'(ov2), 32'(c_ov[j]));
    end
    stall = 1'b0;

    // Flush beats stall with a full depth-3 pipe
    for (int j = 1; j <= 3; j++) begin
      set_in(1'b1, 3'(SEL_PC), 32'h20 + 32'(j));
      step();
    end
    chk("full_d3_out", out3, 32'h21);
    set_in(1'b1, 3'(SEL_PC), 32'h24);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fl_st_d3_out", out3, 32'h0);
    chk("fl_st_d3_valid", 32'(ov3), 32'h0);
    chk("fl_st_d2_valid", 32'(ov2), 32'h0);
    chk("fl_st_d1_valid", 32'(ov1), 32'h0);
    set_in(1'b1, 3'(SEL_FWD), 32'h25);
    step();
    set_in(1'b0, 3'(SEL_FWD), 32'h0);
    chk("post_fl_v1", 32'(ov3), 32'h0);
    step();
    chk("post_fl_v2", 32'(ov3), 32'h0);
    step();
    chk("post_fl_out", out3, 32'h25);
    chk("post_fl_valid", 32'(ov3), 32'h1);

    // Select range checks on the 5-source instance
    src = {5{32'h5A5A_A5A5}};
    chk("err_idle", 32'(erre), 32'h0);
    set_in(1'b1, 3'd4, 32'hCAFE_F00D);
    step();
    chk("sel4_out", oute, 32'hCAFE_F00D);
    chk("sel4_err", 32'(erre), 32'h0);
    set_in(1'b1, 3'd5, 32'h0);
    step();
    chk("sel5_out", oute, 32'h0);
    chk("sel5_valid", 32'(ove), 32'h1);
    chk("sel5_err", 32'(erre), 32'h1);
    set_in(1'b0, 3'd0, 32'h5A5A_A5A5);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", 32'(erre), 32'h0);
    set_in(1'b0, 3'd7, 32'h0);
    step();
    chk("inv_bad_err", 32'(erre), 32'h0);
    chk("inv_bad_out", oute, 32'h0);
    set_in(1'b1, 3'd6, 32'h0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("stall_bad_err", 32'(erre), 32'h0);
    set_in(1'b1, 3'd5, 32'h0);
    step();
    chk("set_again", 32'(erre), 32'h1);
    clr_err = 1'b1;
    step();
    chk("set_beats_clr", 32'(erre), 32'h1);
    set_in(1'b1, 3'd1, 32'h5A5A_A5A5);
    step();
    chk("clr_good_sel", 32'(erre), 32'h0);
    clr_err = 1'b0;
    set_in(1'b1, 3'd7, 32'h0);
    step();
    chk("set_pre_rst", 32'(erre), 32'h1);

    // Asynchronous reset between edges with a full pipe
    for (int j = 1; j <= 3; j++) begin
      set_in(1'b1, 3'(SEL_RS1), 32'h30 + 32'(j));
      step();
    end
    chk("pre_rst_out", out3, 32'h31);
    #2 RST = 1'b1;
    #1;
    chk("arst_d3_out", out3, 32'h0);
    chk("arst_d3_valid", 32'(ov3), 32'h0);
    chk("arst_d1_valid", 32'(ov1), 32'h0);
    chk("arst_err", 32'(erre), 32'h0);
    #1 RST = 1'b0;
    set_in(1'b1, 3'(SEL_UTYPE), 32'h41);
    step();
    chk("post_rst_out", out1, 32'h41);
    chk("post_rst_valid", 32'(ov1), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
